// File: rtl/beta_exe_stage_pkg.sv
// beta_exe_stage_pkg: execute-stage memory opcodes, FSM encodings and bus request type
package beta_exe_stage_pkg;
  localparam logic MEM_LOAD_OP = 1'b0;
  localparam logic MEM_STORE_OP = 1'b1;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;
  localparam logic [1:0] RDMEM_IDLE = 2'b00;
  localparam logic [1:0] RDMEM_WRDY = 2'b01;
  localparam logic [1:0] RDMEM_WVLD = 2'b10;
  localparam logic [1:0] RDMEM_DONE = 2'b11;
  localparam logic [1:0] WDMEM_IDLE = 2'b00;
  localparam logic [1:0] WDMEM_WRDY = 2'b01;
  localparam logic [1:0] WDMEM_WVLD = 2'b10;
  localparam logic [1:0] WDMEM_DONE = 2'b11;
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } dmem_req_t;
endpackage

// File: rtl/beta_dmem_align.sv
// beta_dmem_align: access legality, byte lanes, store replication and load extension
module beta_dmem_align
  import beta_exe_stage_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic        legal,
  output logic [3:0]  be,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);
  logic [31:0] sh;
  // size/offset decode; the load word is shifted down so the addressed lane sits at bit 0
  always_comb begin
    legal = size == MEM_SIZE_WORD ? off == 2'b00 :
            size == MEM_SIZE_HALF ? !off[0] : size == MEM_SIZE_BYTE;
    be = size == MEM_SIZE_WORD ? 4'b1111 :
         size == MEM_SIZE_HALF ? 4'b0011 << {off[1], 1'b0} : 4'b0001 << off;
    store_data = size == MEM_SIZE_HALF ? {2{wdata[15:0]}} :
                 size == MEM_SIZE_BYTE ? {4{wdata[7:0]}} : wdata;
    sh = rdata >> {off, 3'b000};
    load_data = size == MEM_SIZE_HALF ? {{16{sgn & sh[15]}}, sh[15:0]} :
                size == MEM_SIZE_BYTE ? {{24{sgn & sh[7]}}, sh[7:0]} : sh;
  end
endmodule

// File: rtl/beta_dmem_ctrl.sv
// beta_dmem_ctrl: sequences one load/store over a valid/ready data-memory port
module beta_dmem_ctrl
  import beta_exe_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lsu_req_i,
  input  logic              lsu_op_i,
  input  logic [1:0]        lsu_size_i,
  input  logic              lsu_unsigned_n_i,
  input  logic [ADDR_W-1:0] lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic              lsu_err_o,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              dmem_req_valid_o,
  input  logic              dmem_req_ready_i,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [3:0]        dmem_be_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_rsp_valid_i,
  output logic              dmem_rsp_ready_o,
  input  logic [DATA_W-1:0] dmem_rdata_i
);
  logic [1:0] rd_state, wr_state, rd_nxt, wr_nxt, size_q, off_q, sz, off;
  logic sgn_q, err_q, idle, start, legal;
  logic [3:0] be;
  logic [31:0] sdata, ldata, rdata_q;
  dmem_req_t req_q;
  assign idle = rd_state == RDMEM_IDLE && wr_state == WDMEM_IDLE;
  assign start = idle && lsu_req_i;
  assign sz = idle ? lsu_size_i : size_q;
  assign off = idle ? lsu_addr_i[1:0] : off_q;
  beta_dmem_align u_align (
    .size(sz), .off(off), .sgn(sgn_q), .wdata(lsu_wdata_i), .rdata(dmem_rdata_i),
    .legal(legal), .be(be), .store_data(sdata), .load_data(ldata)
  );
  // next state; only the FSM matching the opcode leaves IDLE, and only when both are idle
  always_comb begin
    rd_nxt = rd_state == RDMEM_IDLE ? (start && lsu_op_i == MEM_LOAD_OP ? (legal ? RDMEM_WRDY : RDMEM_DONE) : RDMEM_IDLE) :
             rd_state == RDMEM_WRDY ? (dmem_req_ready_i ? RDMEM_WVLD : RDMEM_WRDY) :
             rd_state == RDMEM_WVLD ? (dmem_rsp_valid_i ? RDMEM_DONE : RDMEM_WVLD) : RDMEM_IDLE;
    wr_nxt = wr_state == WDMEM_IDLE ? (start && lsu_op_i == MEM_STORE_OP ? (legal ? WDMEM_WRDY : WDMEM_DONE) : WDMEM_IDLE) :
             wr_state == WDMEM_WRDY ? (dmem_req_ready_i ? WDMEM_WVLD : WDMEM_WRDY) :
             wr_state == WDMEM_WVLD ? (dmem_rsp_valid_i ? WDMEM_DONE : WDMEM_WVLD) : WDMEM_IDLE;
  end
  // state, captured request and load result; the bus fields only change on a legal accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_state <= RDMEM_IDLE;
      wr_state <= WDMEM_IDLE;
      req_q <= '0;
      size_q <= '0;
      off_q <= '0;
      sgn_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      rd_state <= rd_nxt;
      wr_state <= wr_nxt;
      if (start) begin
        err_q <= !legal;
        rdata_q <= '0;
        if (legal) begin
          req_q <= '{addr: 32'({lsu_addr_i[ADDR_W-1:2], 2'b00}), be: be, we: lsu_op_i, wdata: sdata};
          size_q <= lsu_size_i;
          off_q <= lsu_addr_i[1:0];
          sgn_q <= lsu_unsigned_n_i;
        end
      end
      if (rd_state == RDMEM_WVLD && dmem_rsp_valid_i) rdata_q <= ldata;
    end
  end
  assign lsu_done_o = rd_state == RDMEM_DONE || wr_state == WDMEM_DONE;
  assign dmem_req_valid_o = rd_state == RDMEM_WRDY || wr_state == WDMEM_WRDY;
  assign dmem_rsp_ready_o = rd_state == RDMEM_WVLD || wr_state == WDMEM_WVLD;
  assign lsu_stall_o = !rst && (start || dmem_req_valid_o || dmem_rsp_ready_o);
  assign lsu_err_o = lsu_done_o && err_q;
  assign lsu_rdata_o = lsu_done_o ? rdata_q : '0;
  assign dmem_we_o = req_q.we;
  assign dmem_addr_o = req_q.addr[ADDR_W-1:0];
  assign dmem_be_o = req_q.be;
  assign dmem_wdata_o = req_q.wdata;
endmodule

// File: tb/tb_beta_dmem_ctrl.sv
// tb_beta_dmem_ctrl: scoreboard bench with a wait-state memory model
module tb_beta_dmem_ctrl;
  import beta_exe_stage_pkg::*;
  logic clk = 1'b0, rst = 1'b1;
  logic lsu_req_i = 1'b0, lsu_op_i = 1'b0, lsu_unsigned_n_i = 1'b0;
  logic [1:0] lsu_size_i = 2'b00;
  logic [31:0] lsu_addr_i = '0, lsu_wdata_i = '0;
  logic lsu_stall_o, lsu_done_o, lsu_err_o, dmem_req_valid_o, dmem_we_o, dmem_rsp_ready_o;
  logic [31:0] lsu_rdata_o, dmem_addr_o, dmem_wdata_o;
  logic [3:0] dmem_be_o;
  logic dmem_req_ready_i = 1'b0, dmem_rsp_valid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
    int          lat;
  } exp_t;
  exp_t done_q[$];
  dmem_req_t bus_q[$];
  int checks = 0, errors = 0, cyc = 0, rdy_waits = 0, rsp_waits = 0;
  logic [31:0] mem_word = '0;
  logic force_rsp = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  beta_dmem_ctrl dut (
    .clk(clk), .rst(rst), .lsu_req_i(lsu_req_i), .lsu_op_i(lsu_op_i), .lsu_size_i(lsu_size_i),
    .lsu_unsigned_n_i(lsu_unsigned_n_i), .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
    .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .lsu_err_o(lsu_err_o), .lsu_rdata_o(lsu_rdata_o),
    .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_rsp_valid_i(dmem_rsp_valid_i), .dmem_rsp_ready_o(dmem_rsp_ready_o), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // memory: ready after rdy_waits valid cycles, response rsp_waits cycles after the handshake
  initial begin : mem
    logic req_hs, rsp_hs, r, pend;
    int cnt, rcnt;
    pend = 1'b0;
    cnt = 0;
    rcnt = 0;
    forever begin
      @(posedge clk);
      req_hs = dmem_req_valid_o & dmem_req_ready_i;
      rsp_hs = dmem_rsp_valid_i & dmem_rsp_ready_o;
      r = rst;
      #2;
      if (r) begin
        pend = 1'b0;
        cnt = 0;
        rcnt = 0;
      end else begin
        if (rsp_hs) pend = 1'b0;
        if (req_hs) begin
          pend = 1'b1;
          rcnt = 0;
          cnt = 0;
        end else if (pend) rcnt++;
      end
      cnt = dmem_req_valid_o ? cnt + 1 : 0;
      dmem_req_ready_i = dmem_req_valid_o && cnt > rdy_waits;
      dmem_rsp_valid_i = (pend && rcnt >= rsp_waits) || force_rsp;
      dmem_rdata_i = mem_word;
    end
  end

  // monitor: bus fields checked every valid cycle, completion checked against the scoreboard
  initial begin : mon
    int stall_cnt;
    exp_t e;
    dmem_req_t b;
    stall_cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) stall_cnt = 0;
      else begin
        if (dmem_req_valid_o) begin
          if (bus_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got valid addr %h expected no request", dmem_addr_o);
          end else begin
            b = bus_q[0];
            chk("bus_addr", dmem_addr_o, b.addr);
            chk("bus_be", 32'(dmem_be_o), 32'(b.be));
            chk("bus_we", 32'(dmem_we_o), 32'(b.we));
            chk("bus_wdata", dmem_wdata_o, b.wdata);
            if (dmem_req_ready_i) void'(bus_q.pop_front());
          end
        end
        if (lsu_done_o) begin
          chk("done_stall", 32'(lsu_stall_o), 32'd0);
          if (done_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
          end else begin
            e = done_q.pop_front();
            chk("err", 32'(lsu_err_o), 32'(e.err));
            chk("rdata", lsu_rdata_o, e.rdata);
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("stall_cycles", 32'(stall_cnt), 32'(e.lat));
          end
          stall_cnt = 0;
        end else if (lsu_stall_o) stall_cnt++;
      end
    end
  end

  task automatic issue(input logic op, input logic [1:0] size, input logic sgn, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] word, input int rw, input int sw,
                       input logic xerr, input logic [31:0] xrdata, input logic [3:0] xbe,
                       input logic [31:0] xwdata, input int lat, input logic hold);
    int n;
    exp_t e;
    rdy_waits = rw;
    rsp_waits = sw;
    mem_word = word;
    e = '{xerr, xrdata, cyc + lat, lat};
    done_q.push_back(e);
    if (!xerr) bus_q.push_back('{addr: {addr[31:2], 2'b00}, be: xbe, we: op, wdata: xwdata});
    lsu_op_i = op;
    lsu_size_i = size;
    lsu_unsigned_n_i = sgn;
    lsu_addr_i = addr;
    lsu_wdata_i = wdata;
    lsu_req_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!lsu_done_o && n < 30);
    if (!lsu_done_o) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 30 cycles");
    end
    @(posedge clk);
    #1;
    if (!hold) begin
      lsu_req_i = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(lsu_stall_o), 32'd0);
    chk("rst_done", 32'(lsu_done_o), 32'd0);
    chk("rst_valid", 32'(dmem_req_valid_o), 32'd0);
    chk("rst_rspready", 32'(dmem_rsp_ready_o), 32'd0);
    chk("rst_addr", dmem_addr_o, 32'd0);
    chk("rst_be", 32'(dmem_be_o), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1, 32'h100, 0, 32'hDEADBEEF, 0, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0, 3, 0);
    issue(MEM_LOAD_OP, MEM_SIZE_BYTE, 1, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 32'hFFFFFF80, 4'h8, 32'h0, 3, 0);
    issue(MEM_LOAD_OP, MEM_SIZE_BYTE, 0, 32'h103, 0, 32'h80FF0000, 0, 0, 0, 32'h00000080, 4'h8, 32'h0, 3, 0);
    issue(MEM_STORE_OP, MEM_SIZE_HALF, 0, 32'h102, 32'h1234ABCD, 0, 2, 0, 0, 32'h0, 4'hC, 32'hABCDABCD, 5, 0);
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1, 32'h101, 0, 32'h11111111, 0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0);
    issue(MEM_STORE_OP, MEM_SIZE_BYTE, 0, 32'h001, 32'h00000055, 0, 0, 1, 0, 32'h0, 4'h2, 32'h55555555, 4, 0);
    issue(MEM_LOAD_OP, 2'b11, 0, 32'h000, 0, 32'h22222222, 0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0);
    issue(MEM_STORE_OP, MEM_SIZE_WORD, 0, 32'h102, 32'h99999999, 0, 0, 0, 1, 32'h0, 4'h0, 32'h0, 1, 0);
    issue(MEM_STORE_OP, MEM_SIZE_WORD, 0, 32'h010, 32'hCAFEF00D, 0, 1, 0, 0, 32'h0, 4'hF, 32'hCAFEF00D, 4, 0);
    issue(MEM_LOAD_OP, MEM_SIZE_HALF, 1, 32'h202, 0, 32'h80011234, 0, 0, 0, 32'hFFFF8001, 4'hC, 32'h0, 3, 1);
    issue(MEM_LOAD_OP, MEM_SIZE_BYTE, 0, 32'h201, 0, 32'h0000A500, 0, 0, 0, 32'h000000A5, 4'h2, 32'h0, 3, 0);
    rsp_waits = 5;
    rdy_waits = 0;
    bus_q.push_back('{addr: 32'h300, be: 4'hF, we: 1'b0, wdata: 32'h0});
    lsu_op_i = MEM_LOAD_OP;
    lsu_size_i = MEM_SIZE_WORD;
    lsu_addr_i = 32'h300;
    lsu_wdata_i = 32'h0;
    lsu_req_i = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre_rst_rspready", 32'(dmem_rsp_ready_o), 32'd1);
    #2;
    rst = 1'b1;
    lsu_req_i = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(lsu_stall_o), 32'd0);
    chk("mid_rst_rspready", 32'(dmem_rsp_ready_o), 32'd0);
    chk("mid_rst_valid", 32'(dmem_req_valid_o), 32'd0);
    chk("mid_rst_done", 32'(lsu_done_o), 32'd0);
    chk("mid_rst_addr", dmem_addr_o, 32'd0);
    chk("mid_rst_be", 32'(dmem_be_o), 32'd0);
    chk("mid_rst_we", 32'(dmem_we_o), 32'd0);
    chk("mid_rst_rdata", lsu_rdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_waits = 0;
    @(posedge clk);
    #1;
    force_rsp = 1'b1;
    @(posedge clk);
    #1;
    force_rsp = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_no_done", 32'(lsu_done_o), 32'd0);
    end
    @(posedge clk);
    #1;
    issue(MEM_LOAD_OP, MEM_SIZE_WORD, 1, 32'h300, 0, 32'h01234567, 0, 0, 0, 32'h01234567, 4'hF, 32'h0, 3, 0);
    chk("done_queue_empty", 32'(done_q.size()), 32'd0);
    chk("bus_queue_empty", 32'(bus_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/beta_dmem_ctrl.md
# beta_dmem_ctrl

Data-memory access controller for the execute stage. It accepts one load/store request per instruction from the EX control word (`exe_mem_op_en`, `exe_mem_op`, `exe_mem_op_size`). It sequences the request over a valid/ready data-memory port using the read and write protocol state machines, and stalls the pipeline until the access completes. It produces aligned byte enables, replicated store data, extended load data and a misalignment error.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width. Fixed at 32; other values are unsupported.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `lsu_req_i` in 1: memory operation requested (`exe_mem_op_en`).
- `lsu_op_i` in 1: `MEM_LOAD_OP` / `MEM_STORE_OP`.
- `lsu_size_i` in 2: `MEM_SIZE_WORD` / `MEM_SIZE_HALF` / `MEM_SIZE_BYTE`; 2'b11 is illegal.
- `lsu_unsigned_n_i` in 1: 1 = sign-extend loads, 0 = zero-extend.
- `lsu_addr_i` in `ADDR_W`: byte address.
- `lsu_wdata_i` in 32: store data, right-aligned.
- `lsu_stall_o` out 1: hold the EX stage.
- `lsu_done_o` out 1: one-cycle completion pulse.
- `lsu_err_o` out 1: misaligned or illegal size; valid with `lsu_done_o`.
- `lsu_rdata_o` out 32: extended load result; valid with `lsu_done_o`.
- `dmem_req_valid_o` out 1, `dmem_req_ready_i` in 1: request handshake.
- `dmem_we_o` out 1: 1 = write.
- `dmem_addr_o` out `ADDR_W`: word-aligned address `{addr[ADDR_W-1:2],2'b00}`.
- `dmem_be_o` out 4: byte enables.
- `dmem_wdata_o` out 32: replicated store data.
- `dmem_rsp_valid_i` in 1, `dmem_rsp_ready_o` out 1: response handshake; for stores the response is the write acknowledge.
- `dmem_rdata_i` in 32: read word.

## Operation
- Two 2-bit state registers: `rd_state` (`RDMEM_*`) and `wr_state` (`WDMEM_*`). At most one is non-IDLE at any time.
- States: IDLE, WRDY, WVLD, and DONE = 2'b11.

Transitions (X = RD or WD):
- IDLE, `lsu_req_i=1` and access legal: capture address, size, sign mode and store data into registers. Go to WRDY in the FSM selected by `lsu_op_i`.
- IDLE, request illegal: no bus activity; go to DONE with the error flag set. The load FSM carries the error for loads, the store FSM for stores.
- WRDY: `dmem_req_valid_o=1`. Go to WVLD when `dmem_req_ready_i=1`.
- WVLD: `dmem_rsp_ready_o=1`. When `dmem_rsp_valid_i=1`, register the extended load data and go to DONE.
- DONE: `lsu_done_o=1`, `lsu_stall_o=0`, `lsu_req_i` ignored (the same instruction is still present). Next state is IDLE.

Legality:
- WORD requires `addr[1:0]==0`.
- HALF requires `addr[0]==0`.
- BYTE is always legal.
- Size 2'b11 is always illegal.

Byte enables and store data:
- WORD: be = 1111, data passed through.
- HALF: be = 0011 << (2·addr[1]), data = `{2{wdata[15:0]}}`.
- BYTE: be = 0001 << addr[1:0], data = `{4{wdata[7:0]}}`.

Load data:
- Shift `dmem_rdata_i` right by 8·addr[1:0], then extend from bit 15 (HALF) or bit 7 (BYTE).
- `lsu_rdata_o` is 0 for stores and errors.

Bus outputs:
- `dmem_addr_o`, `dmem_be_o`, `dmem_we_o` and `dmem_wdata_o` are driven from the captured registers.
- They are held stable while `dmem_req_valid_o` is high.

## Timing
- `lsu_stall_o = (IDLE & lsu_req_i) | WRDY | WVLD`. This is combinational, so the stall rises in the same cycle as the request.
- Zero-wait load or store: cycle 0 accept; cycle 1 request handshake; cycle 2 response; cycle 3 DONE. The stall is high for 3 cycles.
- Misaligned access: cycle 0 accept; cycle 1 DONE with `lsu_err_o=1`.
- Each wait-state on ready or on response adds exactly one cycle.
- Only one transaction is outstanding. The memory returns the response no earlier than one cycle after the request handshake.
- A response arriving outside WVLD is ignored.
- Reset (any cycle, including mid-transaction): both FSMs go to IDLE, and every output and captured register goes to 0. An in-flight request is abandoned; the memory model must drop it.

## Structure
Add the following to `beta_exe_stage_pkg`:
- `RDMEM_DONE` = 2'b11 and `WDMEM_DONE` = 2'b11.
- A packed `dmem_req_t` struct with fields `addr`, `be`, `we`, `wdata`.

Sub-module `beta_dmem_align` (combinational) performs the legality check, byte-enable and store-data generation, and load extraction/extension. The FSMs remain in `beta_dmem_ctrl`.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with zero waits: `dmem_be_o`=1111, `dmem_addr_o`=0x100, `lsu_done_o` in cycle 3, `lsu_rdata_o`=0xDEADBEEF.
- LB signed at 0x103, word 0x80FF_0000: be=1000, result 0xFFFFFF80. The same access as LBU gives 0x00000080.
- SH at 0x102, wdata 0x1234ABCD, with 2 ready wait-states: `dmem_wdata_o`=0xABCDABCD, be=1100, fields stable for 3 valid cycles, done in cycle 5.
- LW at 0x101: no `dmem_req_valid_o`, `lsu_done_o` and `lsu_err_o` high in cycle 1, rdata 0.
- `rst` asserted while in WVLD: outputs go to 0 immediately. A later `dmem_rsp_valid_i` pulse produces no `lsu_done_o`.
- Back-to-back loads with `lsu_req_i` held high through DONE: the DONE cycle starts no new access, and the second access is accepted in the following cycle.
